// File: rtl/mu0_param_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mu0_param_core : parametrised MU0 accumulator CPU, Ack wait-state memory |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mu0_param_core #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter bit ACK_EN = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] Data_in,
   input  logic              Ack,
   output logic              Rd,
   output logic              Wr,
   output logic [ADDR_W-1:0] Addr,
   output logic [DATA_W-1:0] Data_out,
   output logic              Fetch,
   output logic              Halted,
   output logic              Illegal
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;
   localparam logic [3:0] OP_AND = 4'h8;
   localparam logic [3:0] OP_ORR = 4'h9;
   localparam logic [3:0] OP_LDI = 4'hA;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              illegal_q, illegal_d;

   logic              done;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] s_field;
   logic              rd_c, wr_c, fetch_c, halted_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] dout_c;

   assign done    = ACK_EN ? Ack : 1'b1;
   assign opcode  = ir_q[DATA_W-1 -: 4];
   assign s_field = ir_q[ADDR_W-1:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_FETCH;
         pc_q      <= '0;
         acc_q     <= '0;
         ir_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         acc_q     <= acc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      acc_d     = acc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      rd_c      = 1'b0;
      wr_c      = 1'b0;
      fetch_c   = 1'b0;
      halted_c  = 1'b0;
      addr_c    = pc_q;
      dout_c    = '0;
      case (state_q)
         ST_FETCH: begin
            rd_c    = 1'b1;
            fetch_c = 1'b1;
            if (done) begin
               ir_d    = Data_in;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            addr_c = s_field;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                  rd_c = 1'b1;
                  if (done) begin
                     state_d = ST_FETCH;
                     case (opcode)
                        OP_ADD:  acc_d = acc_q + Data_in;
                        OP_SUB:  acc_d = acc_q - Data_in;
                        OP_AND:  acc_d = acc_q & Data_in;
                        OP_ORR:  acc_d = acc_q | Data_in;
                        default: acc_d = Data_in;
                     endcase
                  end
               end
               OP_STA: begin
                  wr_c   = 1'b1;
                  dout_c = acc_q;
                  if (done) state_d = ST_FETCH;
               end
               OP_JMP: begin
                  pc_d    = s_field;
                  state_d = ST_FETCH;
               end
               OP_JGE: begin
                  if (!acc_q[DATA_W-1]) pc_d = s_field;
                  state_d = ST_FETCH;
               end
               OP_JNE: begin
                  if (acc_q != '0) pc_d = s_field;
                  state_d = ST_FETCH;
               end
               OP_STP: state_d = ST_HALT;
               OP_LDI: begin
                  acc_d   = {{(DATA_W-ADDR_W){1'b0}}, s_field};
                  state_d = ST_FETCH;
               end
               default: begin
                  illegal_d = 1'b1;
                  state_d   = ST_HALT;
               end
            endcase
         end
         ST_HALT: halted_c = 1'b1;
         default: state_d = ST_FETCH;
      endcase
   end

   // Registers already sit at their reset values; gating keeps the bus quiet while Reset is held.
   assign Rd       = rd_c & ~Reset;
   assign Wr       = wr_c & ~Reset;
   assign Fetch    = fetch_c & ~Reset;
   assign Halted   = halted_c & ~Reset;
   assign Addr     = Reset ? '0 : addr_c;
   assign Data_out = Reset ? '0 : dout_c;
   assign Illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mu0_param_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mu0_param_core : scoreboard bench for mu0_param_core (3 configs)      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mu0_param_core;
   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct { int addr; int data; } wr_t;

   // u0: 16/12, ACK_EN=0
   logic        rst0 = 1'b1;
   logic [15:0] din0, dout0;
   logic [11:0] a0;
   logic        rd0, wr0, f0, h0, il0;
   logic [15:0] mem0 [4096];
   int          exp_fetch0[$];
   wr_t         exp_wr0[$];
   int          rw_halted0 = 0;
   int          e0;
   wr_t         w0;
   assign din0 = mem0[a0];

   mu0_param_core #(.DATA_W(16), .ADDR_W(12), .ACK_EN(1'b0)) u0 (
      .Clk(Clk), .Reset(rst0), .Data_in(din0), .Ack(1'b0), .Rd(rd0), .Wr(wr0),
      .Addr(a0), .Data_out(dout0), .Fetch(f0), .Halted(h0), .Illegal(il0));

   // u1: 16/12, ACK_EN=1, bench-driven wait states
   logic        rst1 = 1'b1;
   logic [15:0] din1, dout1;
   logic [11:0] a1;
   logic        rd1, wr1, f1, h1, il1;
   logic        ack1 = 1'b0;
   logic [15:0] mem1 [4096];
   int          exp_fetch1[$];
   wr_t         exp_wr1[$];
   int          waits1 = 0;
   int          wcnt1 = 0;
   bit          hold_ack1 = 1'b0;
   int          stab_err1 = 0;
   logic [11:0] acc_addr1;
   logic        acc_rd1;
   int          e1;
   wr_t         w1;
   assign din1 = mem1[a1];

   mu0_param_core #(.DATA_W(16), .ADDR_W(12), .ACK_EN(1'b1)) u1 (
      .Clk(Clk), .Reset(rst1), .Data_in(din1), .Ack(ack1), .Rd(rd1), .Wr(wr1),
      .Addr(a1), .Data_out(dout1), .Fetch(f1), .Halted(h1), .Illegal(il1));

   // u2: 24/16, ACK_EN=0; memory aliases on the low 8 address bits
   logic        rst2 = 1'b1;
   logic [23:0] din2, dout2;
   logic [15:0] a2;
   logic        rd2, wr2, f2, h2, il2;
   logic [23:0] mem2 [256];
   int          exp_fetch2[$];
   wr_t         exp_wr2[$];
   int          e2;
   wr_t         w2;
   assign din2 = mem2[a2[7:0]];

   mu0_param_core #(.DATA_W(24), .ADDR_W(16), .ACK_EN(1'b0)) u2 (
      .Clk(Clk), .Reset(rst2), .Data_in(din2), .Ack(1'b0), .Rd(rd2), .Wr(wr2),
      .Addr(a2), .Data_out(dout2), .Fetch(f2), .Halted(h2), .Illegal(il2));

   // Memory models / scoreboards: every completed access pops the next expectation
   always @(negedge Clk) begin
      if (!rst0) begin
         if (h0 && (rd0 || wr0)) rw_halted0++;
         if (rd0 && f0) begin
            n_total++;
            if (exp_fetch0.size() == 0) $display("FAIL fetch0 unexpected addr=%h", a0);
            else begin
               e0 = exp_fetch0.pop_front();
               if (a0 !== 12'(e0)) $display("FAIL fetch0 addr=%h expected=%h", a0, 12'(e0));
               else n_pass++;
            end
         end
         if (wr0) begin
            mem0[a0] = dout0;
            n_total++;
            if (exp_wr0.size() == 0) $display("FAIL write0 unexpected addr=%h data=%h", a0, dout0);
            else begin
               w0 = exp_wr0.pop_front();
               if (a0 !== 12'(w0.addr) || dout0 !== 16'(w0.data))
                  $display("FAIL write0 addr=%h data=%h expected addr=%h data=%h", a0, dout0, 12'(w0.addr), 16'(w0.data));
               else n_pass++;
            end
         end
      end
   end

   always @(negedge Clk) begin
      if (rst1 || !(rd1 || wr1)) begin
         ack1  = 1'b0;
         wcnt1 = 0;
      end else begin
         if (wcnt1 == 0) begin
            acc_addr1 = a1;
            acc_rd1   = rd1;
         end else if (a1 !== acc_addr1 || rd1 !== acc_rd1) stab_err1++;
         if (wcnt1 >= waits1 && !(hold_ack1 && wr1)) begin
            ack1  = 1'b1;
            wcnt1 = 0;
            if (rd1 && f1) begin
               n_total++;
               if (exp_fetch1.size() == 0) $display("FAIL fetch1 unexpected addr=%h", a1);
               else begin
                  e1 = exp_fetch1.pop_front();
                  if (a1 !== 12'(e1)) $display("FAIL fetch1 addr=%h expected=%h", a1, 12'(e1));
                  else n_pass++;
               end
            end
            if (wr1) begin
               mem1[a1] = dout1;
               n_total++;
               if (exp_wr1.size() == 0) $display("FAIL write1 unexpected addr=%h data=%h", a1, dout1);
               else begin
                  w1 = exp_wr1.pop_front();
                  if (a1 !== 12'(w1.addr) || dout1 !== 16'(w1.data))
                     $display("FAIL write1 addr=%h data=%h expected addr=%h data=%h", a1, dout1, 12'(w1.addr), 16'(w1.data));
                  else n_pass++;
               end
            end
         end else begin
            ack1 = 1'b0;
            wcnt1++;
         end
      end
   end

   always @(negedge Clk) begin
      if (!rst2) begin
         if (rd2 && f2) begin
            n_total++;
            if (exp_fetch2.size() == 0) $display("FAIL fetch2 unexpected addr=%h", a2);
            else begin
               e2 = exp_fetch2.pop_front();
               if (a2 !== 16'(e2)) $display("FAIL fetch2 addr=%h expected=%h", a2, 16'(e2));
               else n_pass++;
            end
         end
         if (wr2) begin
            mem2[a2[7:0]] = dout2;
            n_total++;
            if (exp_wr2.size() == 0) $display("FAIL write2 unexpected addr=%h data=%h", a2, dout2);
            else begin
               w2 = exp_wr2.pop_front();
               if (a2 !== 16'(w2.addr) || dout2 !== 24'(w2.data))
                  $display("FAIL write2 addr=%h data=%h expected addr=%h data=%h", a2, dout2, 16'(w2.addr), 24'(w2.data));
               else n_pass++;
            end
         end
      end
   end

   task automatic wait_halt0(input int budget, output int cyc);
      cyc = 0;
      while (h0 !== 1'b1 && cyc < budget) begin @(posedge Clk); #1; cyc++; end
   endtask
   task automatic wait_halt1(input int budget, output int cyc);
      cyc = 0;
      while (h1 !== 1'b1 && cyc < budget) begin @(posedge Clk); #1; cyc++; end
   endtask
   task automatic wait_halt2(input int budget, output int cyc);
      cyc = 0;
      while (h2 !== 1'b1 && cyc < budget) begin @(posedge Clk); #1; cyc++; end
   endtask

   task automatic load_basic(input bit which);
      for (int i = 0; i < 4096; i++) begin
         if (which) mem1[i] = '0; else mem0[i] = '0;
      end
      if (which) begin
         mem1[0] = 16'h0005; mem1[1] = 16'h2006; mem1[2] = 16'h1007; mem1[3] = 16'h7000;
         mem1[5] = 16'd3;    mem1[6] = 16'd4;
      end else begin
         mem0[0] = 16'h0005; mem0[1] = 16'h2006; mem0[2] = 16'h1007; mem0[3] = 16'h7000;
         mem0[5] = 16'd3;    mem0[6] = 16'd4;
      end
   endtask

   task automatic test_reset;
      rst0 = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      n_total++;
      if ({rd0, wr0, f0, h0, il0} !== 5'b0 || a0 !== 12'h000)
         $display("FAIL reset_outputs rd/wr/f/h/il=%b addr=%h expected 00000 addr=000", {rd0, wr0, f0, h0, il0}, a0);
      else n_pass++;
   endtask

   task automatic test_program_nowait;
      int cyc;
      load_basic(1'b0);
      exp_fetch0 = {0, 1, 2, 3};
      exp_wr0.push_back('{addr: 7, data: 7});
      @(posedge Clk); #2 rst0 = 1'b0;
      wait_halt0(8 - 1, cyc);
      n_total++;
      if (h0 !== 1'b0) $display("FAIL nowait_early_halt halted=%b after %0d cycles expected 0", h0, cyc);
      else n_pass++;
      @(posedge Clk); #1;
      n_total++;
      if (h0 !== 1'b1) $display("FAIL nowait_halt_cycle halted=%b after 8 cycles expected 1", h0);
      else n_pass++;
      n_total++;
      if (mem0[7] !== 16'h0007 || a0 !== 12'h004 || il0 !== 1'b0)
         $display("FAIL nowait_final mem7=%h pc=%h illegal=%b expected 0007 004 0", mem0[7], a0, il0);
      else n_pass++;
      n_total++;
      if (exp_fetch0.size() != 0 || exp_wr0.size() != 0)
         $display("FAIL nowait_drain fetch_left=%0d wr_left=%0d expected 0 0", exp_fetch0.size(), exp_wr0.size());
      else n_pass++;
      rst0 = 1'b1;
   endtask

   task automatic test_program_waits;
      int cyc;
      load_basic(1'b1);
      waits1 = 3;
      stab_err1 = 0;
      exp_fetch1 = {0, 1, 2, 3};
      exp_wr1.push_back('{addr: 7, data: 7});
      @(posedge Clk); #2 rst1 = 1'b0;
      wait_halt1(200, cyc);
      // 7 memory accesses of (waits+1) cycles each plus the single-cycle STP exec
      n_total++;
      if (cyc != 7 * (3 + 1) + 1 || h1 !== 1'b1)
         $display("FAIL waits_halt_cycle cycles=%0d halted=%b expected %0d 1", cyc, h1, 7 * 4 + 1);
      else n_pass++;
      n_total++;
      if (stab_err1 != 0) $display("FAIL waits_stable unstable_cycles=%0d expected 0", stab_err1);
      else n_pass++;
      n_total++;
      if (mem1[7] !== 16'h0007 || a1 !== 12'h004 || il1 !== 1'b0)
         $display("FAIL waits_final mem7=%h pc=%h illegal=%b expected 0007 004 0", mem1[7], a1, il1);
      else n_pass++;
      rst1 = 1'b1;
      waits1 = 0;
   endtask

   task automatic test_branches;
      int cyc;
      for (int i = 0; i < 4096; i++) mem0[i] = '0;
      mem0[0] = 16'hA000; mem0[1] = 16'h6009; mem0[2] = 16'hA800; mem0[3] = 16'h3020;
      mem0[4] = 16'h1021; mem0[5] = 16'h5030; mem0[6] = 16'h600A; mem0[10] = 16'h7000;
      mem0[9] = 16'h7000; mem0[16'h30] = 16'h7000; mem0[16'h20] = 16'h0801;
      exp_fetch0 = {0, 1, 2, 3, 4, 5, 6, 10};
      exp_wr0.push_back('{addr: 'h21, data: 'hFFFF});
      @(posedge Clk); #2 rst0 = 1'b0;
      wait_halt0(60, cyc);
      n_total++;
      if (cyc != 16 || a0 !== 12'h00B || il0 !== 1'b0)
         $display("FAIL branches_halt cycles=%0d pc=%h illegal=%b expected 16 00b 0", cyc, a0, il0);
      else n_pass++;
      n_total++;
      if (mem0[16'h21] !== 16'hFFFF || exp_fetch0.size() != 0 || exp_wr0.size() != 0)
         $display("FAIL branches_result mem21=%h fetch_left=%0d wr_left=%0d expected ffff 0 0", mem0[16'h21], exp_fetch0.size(), exp_wr0.size());
      else n_pass++;
      rst0 = 1'b1;
   endtask

   task automatic test_pc_wrap_illegal;
      int cyc;
      for (int i = 0; i < 4096; i++) mem0[i] = '0;
      mem0[0] = 16'h4FFD; mem0[12'hFFD] = 16'h0020; mem0[12'hFFE] = 16'h1000; mem0[12'hFFF] = 16'hA001;
      mem0[16'h20] = 16'hC000;
      exp_fetch0 = {0, 'hFFD, 'hFFE, 'hFFF, 0};
      exp_wr0.push_back('{addr: 0, data: 'hC000});
      rw_halted0 = 0;
      @(posedge Clk); #2 rst0 = 1'b0;
      wait_halt0(60, cyc);
      n_total++;
      if (cyc != 10 || h0 !== 1'b1 || il0 !== 1'b1 || a0 !== 12'h001)
         $display("FAIL wrap_illegal cycles=%0d halted=%b illegal=%b pc=%h expected 10 1 1 001", cyc, h0, il0, a0);
      else n_pass++;
      repeat (6) @(posedge Clk);
      #1;
      n_total++;
      if (rw_halted0 != 0 || il0 !== 1'b1 || exp_fetch0.size() != 0)
         $display("FAIL halt_quiet rw_cycles=%0d illegal=%b fetch_left=%0d expected 0 1 0", rw_halted0, il0, exp_fetch0.size());
      else n_pass++;
      rst0 = 1'b1;
      #1;
      n_total++;
      if (il0 !== 1'b0 || h0 !== 1'b0) $display("FAIL illegal_cleared illegal=%b halted=%b expected 0 0", il0, h0);
      else n_pass++;
   endtask

   task automatic test_reset_mid_access;
      int cyc;
      bit seen;
      for (int i = 0; i < 4096; i++) mem1[i] = '0;
      mem1[0] = 16'hA123; mem1[1] = 16'h1005;
      waits1 = 0;
      hold_ack1 = 1'b1;
      exp_fetch1 = {0, 1};
      @(posedge Clk); #2 rst1 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge Clk);
         if (wr1 === 1'b1) seen = 1'b1;
      end
      n_total++;
      if (!seen || dout1 !== 16'h0123 || a1 !== 12'h005)
         $display("FAIL sta_pending seen=%b data=%h addr=%h expected 1 0123 005", seen, dout1, a1);
      else n_pass++;
      repeat (2) @(posedge Clk);
      #3 rst1 = 1'b1;
      #1;
      n_total++;
      if (wr1 !== 1'b0 || rd1 !== 1'b0 || a1 !== 12'h000 || dout1 !== 16'h0000)
         $display("FAIL reset_abort wr=%b rd=%b addr=%h data=%h expected 0 0 000 0000", wr1, rd1, a1, dout1);
      else n_pass++;
      mem1[0] = 16'h1006; mem1[1] = 16'h7000;
      hold_ack1 = 1'b0;
      exp_fetch1 = {0, 1};
      exp_wr1.push_back('{addr: 6, data: 0});
      @(posedge Clk); #2 rst1 = 1'b0;
      #1;
      n_total++;
      if (rd1 !== 1'b1 || f1 !== 1'b1 || a1 !== 12'h000)
         $display("FAIL restart_fetch rd=%b fetch=%b addr=%h expected 1 1 000", rd1, f1, a1);
      else n_pass++;
      wait_halt1(40, cyc);
      n_total++;
      if (h1 !== 1'b1 || mem1[5] !== 16'h0000 || mem1[6] !== 16'h0000 || exp_wr1.size() != 0)
         $display("FAIL restart_result halted=%b mem5=%h mem6=%h wr_left=%0d expected 1 0000 0000 0", h1, mem1[5], mem1[6], exp_wr1.size());
      else n_pass++;
      rst1 = 1'b1;
   endtask

   task automatic test_wide;
      int cyc;
      for (int i = 0; i < 256; i++) mem2[i] = '0;
      mem2[0] = 24'h000010; mem2[1] = 24'h200011; mem2[2] = 24'h600020; mem2[3] = 24'h100012;
      mem2[4] = 24'hA0ABCD; mem2[5] = 24'h108013; mem2[6] = 24'h700000;
      mem2[16'h10] = 24'hFFFFFF; mem2[16'h11] = 24'h000001; mem2[16'h20] = 24'h700000;
      exp_fetch2 = {0, 1, 2, 3, 4, 5, 6};
      exp_wr2.push_back('{addr: 'h0012, data: 0});
      exp_wr2.push_back('{addr: 'h8013, data: 'h00ABCD});
      @(posedge Clk); #2 rst2 = 1'b0;
      wait_halt2(60, cyc);
      n_total++;
      if (cyc != 14 || a2 !== 16'h0007 || il2 !== 1'b0)
         $display("FAIL wide_halt cycles=%0d pc=%h illegal=%b expected 14 0007 0", cyc, a2, il2);
      else n_pass++;
      n_total++;
      if (exp_fetch2.size() != 0 || exp_wr2.size() != 0)
         $display("FAIL wide_drain fetch_left=%0d wr_left=%0d expected 0 0", exp_fetch2.size(), exp_wr2.size());
      else n_pass++;
      rst2 = 1'b1;
   endtask

   initial begin
      test_reset;
      test_program_nowait;
      test_program_waits;
      test_branches;
      test_pc_wrap_illegal;
      test_reset_mid_access;
      test_wide;
      repeat (2) @(posedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
